// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl_pkg: shared op codes, FSM states and sizing defaults for the CAM controller
package cam_ctrl_pkg;
    localparam int DEF_NB_MEM    = 16;
    localparam int DEF_SIZE_ADDR = 4;
    localparam int KEY_W         = 8;
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_NOP    = 2'b11
    } op_t;
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SRCH,
        S_EVAL,
        S_WR,
        S_RESP
    } state_t;
endpackage

// File: rtl/cam_free_enc.sv
// cam_free_enc: lowest set bit of the free mask plus an any-free flag
module cam_free_enc
    import cam_ctrl_pkg::*;
#(
    parameter int NB_MEM    = DEF_NB_MEM,
    parameter int SIZE_ADDR = DEF_SIZE_ADDR
) (
    input  logic [NB_MEM-1:0]    free,
    output logic [SIZE_ADDR-1:0] idx,
    output logic                 any_free
);
    // scan from the top so the lowest free slot is the last one assigned
    always_comb begin
        idx = '0;
        for (int k = NB_MEM - 1; k >= 0; k--)
            if (free[k]) idx = SIZE_ADDR'(k);
    end
    assign any_free = |free;
endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: command-side controller that issues CAM searches/writes and owns the slot valid bitmap
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int NB_MEM    = DEF_NB_MEM,
    parameter int SIZE_ADDR = DEF_SIZE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [KEY_W-1:0]     cmd_key,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_hit,
    output logic                 resp_full,
    output logic [SIZE_ADDR-1:0] resp_index,
    output logic                 cam_enable,
    output logic                 cam_write,
    output logic [SIZE_ADDR:0]   cam_addr,
    output logic [KEY_W-1:0]     cam_data,
    input  logic [SIZE_ADDR:0]   cam_out,
    input  logic                 cam_found
);
    state_t                state;
    op_t                   op;
    logic [SIZE_ADDR:0]    cnt;
    logic [NB_MEM-1:0]     valid_map;
    logic [SIZE_ADDR-1:0]  ci;
    logic [SIZE_ADDR-1:0]  free_idx;
    logic                  any_free;
    logic                  hit_v;
    logic                  unused_top;

    // only the low index bits are meaningful; the CAM's top bit is ignored
    assign ci         = cam_out[SIZE_ADDR-1:0];
    assign unused_top = cam_out[SIZE_ADDR];
    assign hit_v      = cam_found & valid_map[ci];

    cam_free_enc #(.NB_MEM(NB_MEM), .SIZE_ADDR(SIZE_ADDR)) u_free (
        .free     (~valid_map),
        .idx      (free_idx),
        .any_free (any_free)
    );

    // INIT seeds slot k with value k so CAM contents stay pairwise distinct; then serve one command at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            op         <= OP_NOP;
            cnt        <= '0;
            valid_map  <= '0;
            cmd_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_full  <= 1'b0;
            resp_index <= '0;
            cam_enable <= 1'b0;
            cam_write  <= 1'b0;
            cam_addr   <= '0;
            cam_data   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == (SIZE_ADDR+1)'(NB_MEM)) begin
                        state     <= S_IDLE;
                        cam_write <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cam_write <= 1'b1;
                        cam_addr  <= {1'b0, cnt[SIZE_ADDR-1:0]};
                        cam_data  <= KEY_W'(cnt[SIZE_ADDR-1:0]);
                        cnt       <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        op         <= op_t'(cmd_op);
                        resp_hit   <= 1'b0;
                        resp_full  <= 1'b0;
                        resp_index <= '0;
                        if (op_t'(cmd_op) == OP_NOP) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state      <= S_SRCH;
                            cam_enable <= 1'b1;
                            cam_data   <= cmd_key;
                        end
                    end
                end
                S_SRCH: begin
                    cam_enable <= 1'b0;
                    state      <= S_EVAL;
                end
                S_EVAL: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    if (op == OP_INSERT && !cam_found && any_free) begin
                        state      <= S_WR;
                        resp_valid <= 1'b0;
                        cam_write  <= 1'b1;
                        cam_addr   <= {1'b0, free_idx};
                        resp_index <= free_idx;
                    end else if (op == OP_INSERT) begin
                        resp_hit   <= hit_v;
                        resp_full  <= !cam_found;
                        resp_index <= cam_found ? ci : '0;
                        if (cam_found) valid_map[ci] <= 1'b1;
                    end else begin
                        resp_hit   <= hit_v;
                        resp_index <= hit_v ? ci : '0;
                        if (op == OP_DELETE && hit_v) valid_map[ci] <= 1'b0;
                    end
                end
                S_WR: begin
                    cam_write             <= 1'b0;
                    valid_map[resp_index] <= 1'b1;
                    state                 <= S_RESP;
                    resp_valid            <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed bench for cam_ctrl driving a behavioural 16x8 CAM
module tb_cam_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b11;
    logic [7:0] cmd_key = 8'h00;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       resp_hit;
    logic       resp_full;
    logic [3:0] resp_index;
    logic       cam_enable;
    logic       cam_write;
    logic [4:0] cam_addr;
    logic [7:0] cam_data;
    logic [4:0] cam_out;
    logic       cam_found;
    logic       cam_match;
    logic       rst_n;
    logic [7:0] mem [16];
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int overlap = 0;
    int addr_hi = 0;

    always #5 clk = ~clk;
    assign rst_n = ~rst;

    cam_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_key    (cmd_key),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_full  (resp_full),
        .resp_index (resp_index),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out),
        .cam_found  (cam_found)
    );

    // behavioural CAM: combinational OR of matching indices, registered found flag
    always_comb begin
        cam_out   = 5'd0;
        cam_match = 1'b0;
        for (int k = 0; k < 16; k++)
            if (mem[k] == cam_data) begin
                cam_out   = cam_out | 5'(k);
                cam_match = 1'b1;
            end
    end

    always @(posedge clk) begin
        if (!rst_n) cam_found <= 1'b0;
        else begin
            if (cam_write) mem[cam_addr[3:0]] <= cam_data;
            if (cam_enable) cam_found <= cam_match;
        end
    end

    always @(posedge clk) begin
        if (cam_write) wr_cnt <= wr_cnt + 1;
        if (cam_write && cam_enable) overlap <= overlap + 1;
        if (cam_addr[4]) addr_hi <= addr_hi + 1;
    end

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] key,
                          output logic hit, output logic full, output logic [3:0] idx, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL accept_timeout: cmd_ready low for %0d cycles, need high", n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        hit  = resp_hit;
        full = resp_full;
        idx  = resp_index;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        total++;
        if (n !== 17) begin
            bad++;
            $display("FAIL %s_ready_delay: got %0d cycles, need 17", tag, n);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (mem[k] !== 8'(k)) begin
                bad++;
                $display("FAIL %s_slot%0d: got %h, need %h", tag, k, mem[k], 8'(k));
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, resp_valid, cam_write, cam_enable, cam_addr} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, need 0", {cmd_ready, resp_valid, cam_write, cam_enable, cam_addr});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_init("init");
    endtask

    task automatic test_insert_lookup();
        logic h, f;
        logic [3:0] ix;
        int lat, w0;
        w0 = wr_cnt;
        do_cmd(2'b01, 8'hA5, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b0, 4'd0} || lat !== 4 || wr_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL ins_a5: got h=%b f=%b i=%0d lat=%0d wr=%0d, need 0 0 0 4 1", h, f, ix, lat, wr_cnt - w0);
        end
        do_cmd(2'b00, 8'hA5, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b1, 1'b0, 4'd0} || lat !== 3) begin
            bad++;
            $display("FAIL look_a5: got h=%b f=%b i=%0d lat=%0d, need 1 0 0 3", h, f, ix, lat);
        end
        do_cmd(2'b00, 8'h3C, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b0, 4'd0} || lat !== 3) begin
            bad++;
            $display("FAIL look_3c: got h=%b f=%b i=%0d lat=%0d, need 0 0 0 3", h, f, ix, lat);
        end
        do_cmd(2'b11, 8'hA5, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b0, 4'd0} || lat !== 1) begin
            bad++;
            $display("FAIL nop: got h=%b f=%b i=%0d lat=%0d, need 0 0 0 1", h, f, ix, lat);
        end
    endtask

    task automatic test_revive();
        logic h, f;
        logic [3:0] ix;
        int lat, w0;
        do_cmd(2'b00, 8'h05, h, f, ix, lat);
        total++;
        if ({h, ix} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL look_stale05: got h=%b i=%0d, need 0 0", h, ix);
        end
        w0 = wr_cnt;
        do_cmd(2'b01, 8'h05, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b0, 4'd5} || lat !== 3 || wr_cnt !== w0) begin
            bad++;
            $display("FAIL revive05: got h=%b f=%b i=%0d lat=%0d wr=%0d, need 0 0 5 3 0", h, f, ix, lat, wr_cnt - w0);
        end
        do_cmd(2'b00, 8'h05, h, f, ix, lat);
        total++;
        if ({h, ix} !== {1'b1, 4'd5}) begin
            bad++;
            $display("FAIL look05: got h=%b i=%0d, need 1 5", h, ix);
        end
    endtask

    task automatic test_dup_insert();
        logic h, f;
        logic [3:0] ix;
        int lat, w0, p0;
        p0 = $countones(dut.valid_map);
        w0 = wr_cnt;
        do_cmd(2'b01, 8'hA5, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b1, 1'b0, 4'd0} || wr_cnt !== w0) begin
            bad++;
            $display("FAIL dup_a5: got h=%b f=%b i=%0d wr=%0d, need 1 0 0 0", h, f, ix, wr_cnt - w0);
        end
        total++;
        if ($countones(dut.valid_map) !== 2 || p0 !== 2) begin
            bad++;
            $display("FAIL dup_popcount: got %0d then %0d, need 2 then 2", p0, $countones(dut.valid_map));
        end
    endtask

    task automatic test_full();
        logic h, f;
        logic [3:0] ix;
        int lat, w0;
        int slots[14] = '{1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        for (int j = 0; j < 14; j++) begin
            do_cmd(2'b01, 8'(8'h80 + j), h, f, ix, lat);
            total++;
            if ({h, f, ix} !== {1'b0, 1'b0, 4'(slots[j])}) begin
                bad++;
                $display("FAIL fill%0d: got h=%b f=%b i=%0d, need 0 0 %0d", j, h, f, ix, slots[j]);
            end
        end
        w0 = wr_cnt;
        do_cmd(2'b01, 8'h99, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b1, 4'd0} || wr_cnt !== w0 || lat !== 3) begin
            bad++;
            $display("FAIL full: got h=%b f=%b i=%0d wr=%0d lat=%0d, need 0 1 0 0 3", h, f, ix, wr_cnt - w0, lat);
        end
        do_cmd(2'b10, 8'h82, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b1, 1'b0, 4'd3} || lat !== 3) begin
            bad++;
            $display("FAIL del82: got h=%b f=%b i=%0d lat=%0d, need 1 0 3 3", h, f, ix, lat);
        end
        do_cmd(2'b00, 8'h82, h, f, ix, lat);
        total++;
        if ({h, ix} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL look_deleted: got h=%b i=%0d, need 0 0", h, ix);
        end
        w0 = wr_cnt;
        do_cmd(2'b01, 8'h99, h, f, ix, lat);
        total++;
        if ({h, f, ix} !== {1'b0, 1'b0, 4'd3} || lat !== 4 || wr_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL reins99: got h=%b f=%b i=%0d lat=%0d wr=%0d, need 0 0 3 4 1", h, f, ix, lat, wr_cnt - w0);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_key   = 8'h99;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({resp_valid, resp_hit, resp_full, resp_index, cmd_ready} !== {1'b1, 1'b1, 1'b0, 4'd3, 1'b0}) begin
                bad++;
                $display("FAIL stall%0d: got v=%b h=%b f=%b i=%0d rdy=%b, need 1 1 0 3 0",
                         c, resp_valid, resp_hit, resp_full, resp_index, cmd_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_key   = 8'hA5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        total++;
        if (cam_enable !== 1'b1) begin
            bad++;
            $display("FAIL srch_enable: got %b, need 1", cam_enable);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({resp_valid, cmd_ready, cam_enable, cam_write} !== 4'd0 || dut.valid_map !== 16'd0) begin
            bad++;
            $display("FAIL midop_reset: got v=%b rdy=%b en=%b wr=%b map=%h, need 0 0 0 0 0000",
                     resp_valid, cmd_ready, cam_enable, cam_write, dut.valid_map);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_revive();
        test_dup_insert();
        test_full();
        test_stall();
        test_reset_midop();
        total++;
        if (overlap !== 0 || addr_hi !== 0) begin
            bad++;
            $display("FAIL invariants: got overlap=%0d addr_hi=%0d, need 0 0", overlap, addr_hi);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
